// File: rtl/binary4_pkg.sv
// Shared constants and types for the binary4 registered adder.
// Optional overflow flag is enabled with BINARY4_OVF_EN.
package binary4_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    typedef logic [WIDTH_DEFAULT-1:0] operand_t;

    // Registered result word, carry kept next to the sum bits.
    typedef struct packed {
        logic     co;
        operand_t s;
    } result_t;

endpackage

// File: rtl/binary4_if.sv
// Operand/result bundle for binary4; the ovf wire exists only with BINARY4_OVF_EN.
interface binary4_if
    import binary4_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             out_valid;
`ifdef BINARY4_OVF_EN
    logic             ovf;
`endif

    modport master (
        output a, b, cin, in_valid,
        input  s, co, out_valid
`ifdef BINARY4_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  a, b, cin, in_valid,
        output s, co, out_valid
`ifdef BINARY4_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/binary4_full_adder.sv
// One-bit full adder cell, chained by binary4 to form the ripple-carry path.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/binary4.sv
// Registered WIDTH-bit ripple-carry adder with one-cycle latency and valid strobe.
// Define BINARY4_OVF_EN to add the registered two's-complement overflow flag.
module binary4
    import binary4_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    binary4_if.slave  bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             out_valid_q;

    assign carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q         <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                s_q  <= sum;
                co_q <= carry[WIDTH];
            end
        end
    end

    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.out_valid = out_valid_q;

`ifdef BINARY4_OVF_EN
    logic ovf_q;

    // Same-sign operands whose sum flips sign overflowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_q <= (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.a[WIDTH-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_binary4.sv
// Self-checking bench for binary4 (WIDTH=4); overflow checks follow BINARY4_OVF_EN.
module tb_binary4;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    // Reference model state: what the outputs must show after the next edge.
    int   m_s;
    int   m_co;
    int   m_ov;
    int   m_v;

    binary4_if #(.WIDTH(4)) bus ();

    binary4 #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int a;
        int b;
        int cin;
        int exp_s;
        int exp_co;
        int exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed-range and unsigned-sum view of the addition.
    task automatic model(input int r, input int v, input int a, input int b, input int cin);
        int tot;
        int sa;
        int sb;
        int st;
        if (r != 0) begin
            m_s = 0; m_co = 0; m_ov = 0; m_v = 0;
        end else if (v != 0) begin
            tot  = a + b + cin;
            m_s  = tot % 16;
            m_co = tot / 16;
            sa   = (a >= 8) ? a - 16 : a;
            sb   = (b >= 8) ? b - 16 : b;
            st   = sa + sb + cin;
            m_ov = (st > 7 || st < -8) ? 1 : 0;
            m_v  = 1;
        end else begin
            m_v = 0;
        end
    endtask

    task automatic cycle(input string name, input int r, input int v,
                         input int a, input int b, input int cin);
        rst          = r[0];
        bus.in_valid = v[0];
        bus.a        = a[3:0];
        bus.b        = b[3:0];
        bus.cin      = cin[0];
        model(r, v, a, b, cin);
        @(posedge clk);
        #1;
        chk({name, ".s"}, 32'(bus.s), 32'(m_s));
        chk({name, ".co"}, 32'(bus.co), 32'(m_co));
        chk({name, ".out_valid"}, 32'(bus.out_valid), 32'(m_v));
`ifdef BINARY4_OVF_EN
        chk({name, ".ovf"}, 32'(bus.ovf), 32'(m_ov));
`endif
    endtask

    initial begin
        vec_t dir[5];
        vec_t ov[3];
        int   pulses;
        tests = 0;
        fails = 0;

        dir[0] = '{a: 4'b0001, b: 4'b0011, cin: 0, exp_s: 4'b0100, exp_co: 0, exp_ovf: 0};
        dir[1] = '{a: 4'b0101, b: 4'b1011, cin: 0, exp_s: 4'b0000, exp_co: 1, exp_ovf: 0};
        dir[2] = '{a: 4'b1101, b: 4'b0011, cin: 1, exp_s: 4'b0001, exp_co: 1, exp_ovf: 0};
        dir[3] = '{a: 4'b1001, b: 4'b0011, cin: 1, exp_s: 4'b1101, exp_co: 0, exp_ovf: 0};
        dir[4] = '{a: 4'b1111, b: 4'b1101, cin: 1, exp_s: 4'b1101, exp_co: 1, exp_ovf: 0};

        ov[0] = '{a: 4'b0111, b: 4'b0001, cin: 0, exp_s: 4'b1000, exp_co: 0, exp_ovf: 1};
        ov[1] = '{a: 4'b1000, b: 4'b1000, cin: 0, exp_s: 4'b0000, exp_co: 1, exp_ovf: 1};
        ov[2] = '{a: 4'b0101, b: 4'b1011, cin: 0, exp_s: 4'b0000, exp_co: 1, exp_ovf: 0};

        // Reset held two cycles with valid operands present.
        cycle("reset0", 1, 1, 15, 15, 1);
        cycle("reset1", 1, 1, 15, 15, 1);
        chk("reset.s_zero", 32'(bus.s), 32'd0);
        chk("reset.ov_zero", 32'(bus.out_valid), 32'd0);

        // Directed back-to-back adds against table constants.
        for (int unsigned i = 0; i < 5; i++) begin
            cycle("dir", 0, 1, dir[i].a, dir[i].b, dir[i].cin);
            chk("dir.tbl_s", 32'(bus.s), 32'(dir[i].exp_s));
            chk("dir.tbl_co", 32'(bus.co), 32'(dir[i].exp_co));
        end

        // Hold: one result then three idle cycles; exactly one valid pulse.
        pulses = 0;
        cycle("hold_load", 0, 1, 3, 3, 0);
        pulses += int'(bus.out_valid);
        for (int unsigned i = 0; i < 3; i++) begin
            cycle("hold_idle", 0, 0, $urandom_range(15), $urandom_range(15), $urandom_range(1));
            pulses += int'(bus.out_valid);
        end
        chk("hold.s", 32'(bus.s), 32'b0110);
        chk("hold.co", 32'(bus.co), 32'd0);
        chk("hold.pulses", 32'(pulses), 32'd1);

`ifdef BINARY4_OVF_EN
        for (int unsigned i = 0; i < 3; i++) begin
            cycle("ovf", 0, 1, ov[i].a, ov[i].b, ov[i].cin);
            chk("ovf.tbl_s", 32'(bus.s), 32'(ov[i].exp_s));
            chk("ovf.tbl_co", 32'(bus.co), 32'(ov[i].exp_co));
            chk("ovf.tbl_ovf", 32'(bus.ovf), 32'(ov[i].exp_ovf));
        end
`else
        for (int unsigned i = 0; i < 3; i++) begin
            cycle("ovf_sum", 0, 1, ov[i].a, ov[i].b, ov[i].cin);
            chk("ovf_sum.tbl_s", 32'(bus.s), 32'(ov[i].exp_s));
        end
`endif

        // Reset mid-stream discards the coincident operand.
        cycle("pre_rst", 0, 1, 9, 4, 0);
        cycle("mid_rst", 1, 1, 15, 15, 1);
        chk("mid_rst.s_zero", 32'(bus.s), 32'd0);
        chk("mid_rst.co_zero", 32'(bus.co), 32'd0);
        cycle("post_rst", 0, 1, 6, 7, 1);
        chk("post_rst.tbl_s", 32'(bus.s), 32'd14);

        // Exhaustive back-to-back sweep.
        for (int unsigned c = 0; c < 2; c++)
            for (int unsigned x = 0; x < 16; x++)
                for (int unsigned y = 0; y < 16; y++)
                    cycle("exh", 0, 1, int'(x), int'(y), int'(c));

        // Random traffic with sparse valid gaps and occasional resets.
        for (int unsigned i = 0; i < 300; i++)
            cycle("rand", ($urandom_range(15) == 0) ? 1 : 0, int'($urandom_range(3) != 0),
                  $urandom_range(15), $urandom_range(15), $urandom_range(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/binary4.md
BINARY4 -- requirements
Module: binary4

Interface
REQ-001 Parameter WIDTH, default 4, operand width; the block SHALL be verified at WIDTH=4 only.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a  input  WIDTH  addend A, unsigned.
REQ-005 b  input  WIDTH  addend B, unsigned.
REQ-006 cin  input  1  carry-in.
REQ-007 in_valid  input  1  a/b/cin are sampled this cycle when high.
REQ-008 s  output  WIDTH  registered sum, low WIDTH bits of a+b+cin.
REQ-009 co  output  1  registered carry-out, bit WIDTH of a+b+cin.
REQ-010 out_valid  output  1  high for one cycle when s/co hold a new result.
REQ-011 ovf  output  1  registered two's-complement overflow flag; present only with BINARY4_OVF_EN.

Function
REQ-012 {co,s} SHALL equal a+b+cin, computed at WIDTH+1 bits with no truncation of the carry.
REQ-013 Latency SHALL be exactly 1 cycle: operands sampled on edge N with in_valid=1 appear on s/co, with out_valid=1, after edge N.
REQ-014 With in_valid=0 at an edge, s, co and ovf SHALL hold their previous values and out_valid SHALL be 0.
REQ-015 Back-to-back in_valid=1 SHALL produce one result per cycle with no bubbles; there is no backpressure.
REQ-016 Sum SHALL wrap modulo 2^WIDTH; all-ones+all-ones+1 gives s=all-ones, co=1.
REQ-017 The add path SHALL be a ripple-carry chain: carry into bit 0 is cin, carry out of bit WIDTH-1 is co.
REQ-018 With BINARY4_OVF_EN defined, ovf SHALL be 1 when a[MSB]==b[MSB] and sum[MSB]!=a[MSB], and 0 otherwise; it is updated under the same rules as s.

Reset
REQ-019 While rst=1 at a clock edge, s, co, out_valid and ovf SHALL be 0 after that edge, regardless of in_valid.
REQ-020 rst SHALL take priority over in_valid; an operand presented in the same cycle as reset SHALL be discarded.
REQ-021 The first valid operand after rst deasserts SHALL produce a result after one edge.

Configuration
REQ-022 Macro BINARY4_OVF_EN: when defined, the ovf port and its register are compiled in; when undefined, the port and logic are absent and all other behaviour is identical.

Structure
REQ-023 Package binary4_pkg SHALL hold the WIDTH default constant and a typedef for a WIDTH-bit operand.
REQ-024 One sub-module, full_adder (a, b, ci -> s, co), SHALL be instantiated WIDTH times to form the ripple chain; binary4 holds only the chain, the output registers and the valid logic.

Verification
REQ-025 Reset: rst=1 for 2 cycles with in_valid=1 -> s=0000, co=0, out_valid=0, ovf=0.
REQ-026 Directed adds, one per cycle with in_valid=1, checked one cycle later:
- 0001+0011+0 -> s=0100, co=0
- 0101+1011+0 -> s=0000, co=1
- 1101+0011+1 -> s=0001, co=1
- 1001+0011+1 -> s=1101, co=0
- 1111+1101+1 -> s=1101, co=1
REQ-027 Hold: present 0011+0011+0, then drop in_valid for 3 cycles -> s=0110 and co=0 hold; out_valid pulses exactly once.
REQ-028 Overflow (BINARY4_OVF_EN): 0111+0001+0 -> s=1000, ovf=1; 1000+1000+0 -> s=0000, co=1, ovf=1; 0101+1011+0 -> ovf=0.
REQ-029 Reset mid-stream: assert rst in the same cycle as in_valid=1 with 1111+1111+1 -> outputs 0, no out_valid; the next valid add completes normally.
REQ-030 Exhaustive: all 512 (a,b,cin) combinations back-to-back -> each {co,s} equals the reference sum one cycle later.
